// File: rtl/led_matrix_pkg.sv
// Shared types and default sizing for the LED matrix scanner.
// The scanner multiplexes a Game of Life board onto a row/column LED matrix.
package led_matrix_pkg;

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    localparam int DEFAULT_N              = 5;
    localparam int DEFAULT_CYCLES_PER_ROW = 1000;
    localparam int DEFAULT_BLANK_CYCLES   = 2;

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for the scanner: counts enabled cycles and flags the last cycle
// of the current limit. The caller clears it on the terminal cycle.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ena) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit - W'(1));

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver for the Game of Life board, with a
// per-frame snapshot so mid-scan generation steps never tear the image.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int CYCLES_PER_ROW = DEFAULT_CYCLES_PER_ROW,
    parameter int BLANK_CYCLES   = DEFAULT_BLANK_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N*N-1:0]       cells,
    output logic [N-1:0]         rows,
    output logic [N-1:0]         cols,
    output logic [$clog2(N)-1:0] row_idx,
    output logic                 frame_done
);

    localparam int RW   = $clog2(N);
    localparam int MAXL = (CYCLES_PER_ROW > BLANK_CYCLES) ? CYCLES_PER_ROW : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [CW-1:0] DRIVE_LIMIT = CW'(CYCLES_PER_ROW);
    localparam logic [CW-1:0] BLANK_LIMIT = CW'(BLANK_CYCLES);
    localparam logic [RW-1:0] LAST_ROW    = RW'(N - 1);
    localparam logic [N-1:0]  ROW_ONE     = {{(N-1){1'b0}}, 1'b1};

    scan_state_t      state, state_d;
    logic [RW-1:0]    row_d;
    logic [N*N-1:0]   snapshot, snap_d;
    logic [CW-1:0]    limit, count;
    logic             tc, load, clear;
    logic [N-1:0]     rows_d, cols_d;
    logic             frame_d;

    scan_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .clear (clear),
        .limit (limit),
        .count (count),
        .done  (tc)
    );

    // Outputs are registered from the next-state decode so they line up with
    // the state the scanner occupies after each edge.
    always_comb begin
        state_d = state;
        row_d   = row_idx;
        limit   = (state == S_DRIVE) ? DRIVE_LIMIT : BLANK_LIMIT;
        clear   = ena && tc;
        load    = ena && (state == S_BLANK) && (row_idx == '0) && (count == '0);
        snap_d  = load ? cells : snapshot;
        frame_d = ena && tc && (state == S_DRIVE) && (row_idx == LAST_ROW);
        rows_d  = '0;
        cols_d  = '1;

        if (ena && tc) begin
            case (state)
                S_BLANK: state_d = S_DRIVE;
                S_DRIVE: begin
                    state_d = S_BLANK;
                    row_d   = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
                end
                default: state_d = S_BLANK;
            endcase
        end

        if (ena && (state_d == S_DRIVE)) begin
            rows_d = ROW_ONE << row_d;
            for (int r = 0; r < N; r++) begin
                if (row_d == RW'(r)) begin
                    cols_d = ~snap_d[r*N +: N];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_BLANK;
            row_idx    <= '0;
            snapshot   <= '0;
            rows       <= '0;
            cols       <= '1;
            frame_done <= 1'b0;
        end else begin
            if (ena) begin
                state    <= state_d;
                row_idx  <= row_d;
                snapshot <= snap_d;
            end
            rows       <= rows_d;
            cols       <= cols_d;
            frame_done <= frame_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed checks of the LED matrix scanner with N=3, 4 drive and 2 blank cycles.
module tb_led_matrix_scanner;

    localparam int FRAME = 18;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       ena   = 1'b0;
    logic [8:0] cells = '0;
    logic [2:0] rows;
    logic [2:0] cols;
    logic [1:0] row_idx;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    logic [8:0] pat_a   = 9'b100_010_001;
    logic [8:0] pat_b   = 9'b011_101_110;
    logic [8:0] pat_all = 9'b111_111_111;

    // Expected row drive after edge k of a frame (k=0 is the cycle after reset release).
    logic [2:0] rows_tbl [FRAME] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                                     3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010,
                                     3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100};

    led_matrix_scanner #(.N(3), .CYCLES_PER_ROW(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cells      (cells),
        .rows       (rows),
        .cols       (cols),
        .row_idx    (row_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_cols(input logic [8:0] pat, input logic [2:0] r);
        case (r)
            3'b001:  return ~pat[2:0];
            3'b010:  return ~pat[5:3];
            3'b100:  return ~pat[8:6];
            default: return 3'b111;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ena = 1'b1;
        cells = pat_a;
        repeat (3) tick();
        checks++; if (rows !== 3'b000) begin errors++; $display("FAIL reset_rows got=%b want=000", rows); end
        checks++; if (cols !== 3'b111) begin errors++; $display("FAIL reset_cols got=%b want=111", cols); end
        checks++; if (row_idx !== 2'd0) begin errors++; $display("FAIL reset_row_idx got=%0d want=0", row_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    endtask

    task automatic test_static_frame;
        int p;
        logic [2:0] er;
        cells = pat_a;
        ena   = 1'b1;
        do_reset();
        for (int k = 0; k <= 2 * FRAME; k++) begin
            p  = k % FRAME;
            er = rows_tbl[p];
            checks++; if (rows !== er) begin errors++; $display("FAIL static_rows k=%0d got=%b want=%b", k, rows, er); end
            checks++; if (cols !== exp_cols(pat_a, er)) begin errors++; $display("FAIL static_cols k=%0d got=%b want=%b", k, cols, exp_cols(pat_a, er)); end
            checks++; if (row_idx !== 2'(p / 6)) begin errors++; $display("FAIL static_row_idx k=%0d got=%0d want=%0d", k, row_idx, p / 6); end
            checks++; if (frame_done !== (p == 0 && k > 0)) begin errors++; $display("FAIL static_frame_done k=%0d got=%b want=%b", k, frame_done, (p == 0 && k > 0)); end
            tick();
        end
    endtask

    task automatic test_tear_free;
        int p;
        logic [2:0] er;
        logic [8:0] pat;
        cells = pat_a;
        ena   = 1'b1;
        do_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 9) cells = pat_all;
            p   = k % FRAME;
            er  = rows_tbl[p];
            pat = (k >= FRAME) ? pat_all : pat_a;
            checks++; if (rows !== er) begin errors++; $display("FAIL tear_rows k=%0d got=%b want=%b", k, rows, er); end
            checks++; if (cols !== exp_cols(pat, er)) begin errors++; $display("FAIL tear_cols k=%0d got=%b want=%b", k, cols, exp_cols(pat, er)); end
            checks++; if (frame_done !== (p == 0 && k > 0)) begin errors++; $display("FAIL tear_frame_done k=%0d got=%b want=%b", k, frame_done, (p == 0 && k > 0)); end
            tick();
        end
    endtask

    task automatic test_pause;
        logic [2:0] er;
        cells = pat_a;
        ena   = 1'b1;
        do_reset();
        repeat (9) tick();
        checks++; if (rows !== 3'b010) begin errors++; $display("FAIL pause_pre_rows got=%b want=010", rows); end
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (rows !== 3'b000) begin errors++; $display("FAIL pause_rows i=%0d got=%b want=000", i, rows); end
            checks++; if (cols !== 3'b111) begin errors++; $display("FAIL pause_cols i=%0d got=%b want=111", i, cols); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL pause_frame_done i=%0d got=%b want=0", i, frame_done); end
            checks++; if (row_idx !== 2'd1) begin errors++; $display("FAIL pause_row_idx i=%0d got=%0d want=1", i, row_idx); end
        end
        ena = 1'b1;
        for (int k = 20; k <= 28; k++) begin
            tick();
            er = rows_tbl[(k - 10) % FRAME];
            checks++; if (rows !== er) begin errors++; $display("FAIL resume_rows k=%0d got=%b want=%b", k, rows, er); end
            checks++; if (cols !== exp_cols(pat_a, er)) begin errors++; $display("FAIL resume_cols k=%0d got=%b want=%b", k, cols, exp_cols(pat_a, er)); end
            checks++; if (frame_done !== (k == 28)) begin errors++; $display("FAIL resume_frame_done k=%0d got=%b want=%b", k, frame_done, (k == 28)); end
        end
    endtask

    task automatic test_mid_reset;
        logic [2:0] er;
        cells = pat_a;
        ena   = 1'b1;
        do_reset();
        repeat (15) tick();
        checks++; if (rows !== 3'b100) begin errors++; $display("FAIL midrst_pre_rows got=%b want=100", rows); end
        cells = pat_b;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (rows !== 3'b000) begin errors++; $display("FAIL midrst_async_rows got=%b want=000", rows); end
        checks++; if (cols !== 3'b111) begin errors++; $display("FAIL midrst_async_cols got=%b want=111", cols); end
        checks++; if (row_idx !== 2'd0) begin errors++; $display("FAIL midrst_async_row_idx got=%0d want=0", row_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_async_frame_done got=%b want=0", frame_done); end
        repeat (3) tick();
        rst = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            er = rows_tbl[k % FRAME];
            checks++; if (rows !== er) begin errors++; $display("FAIL midrst_rows k=%0d got=%b want=%b", k, rows, er); end
            checks++; if (cols !== exp_cols(pat_b, er)) begin errors++; $display("FAIL midrst_cols k=%0d got=%b want=%b", k, cols, exp_cols(pat_b, er)); end
            checks++; if (frame_done !== (k == FRAME)) begin errors++; $display("FAIL midrst_frame_done k=%0d got=%b want=%b", k, frame_done, (k == FRAME)); end
            tick();
        end
    endtask

    task automatic test_invariants;
        logic prev_fd;
        prev_fd = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cells = 9'($urandom);
            ena   = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (!$onehot0(rows)) begin errors++; $display("FAIL inv_onehot i=%0d got=%b want=onehot0", i, rows); end
            checks++; if (rows == 3'b000 && cols !== 3'b111) begin errors++; $display("FAIL inv_blank_cols i=%0d got=%b want=111", i, cols); end
            checks++; if (prev_fd && frame_done) begin errors++; $display("FAIL inv_fd_double i=%0d got=11 want=not both", i); end
            prev_fd = frame_done;
        end
    endtask

    initial begin
        $display("[TB] led_matrix_scanner bench start");
        test_reset();
        test_static_frame();
        test_tear_free();
        test_pause();
        test_mid_reset();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
